exmem_cond: RTL
===============

Name: exmem_cond

Overview:
- Execute-to-memory boundary of the 5-stage ARM-subset pipeline. It consumes the control bundle launched by the ID/EXE register plus the execute-stage ALU results.
- Holds the architectural NZCV flags register and evaluates each instruction's 4-bit condition field against it.
- Gates register, memory and PC writes for failed conditions, then registers the surviving bundle into the MEM stage.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
DATA_W, 32, width of ALU result and store data
REG_AW, 4, register-file address width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_e  in  1  instruction in EXE is real (not a bubble)
RegWriteE  in  1  raw register-write enable from ID/EXE
MemWriteE  in  1  raw memory-write enable
MemtoRegE  in  1  writeback selects memory data
PCSrcE  in  1  raw PC-write (branch or write to R15)
CondE  in  4  ARM condition field
FlagWriteE  in  2  [1]=update N,Z; [0]=update C,V
ALUFlagsE  in  4  {N,Z,C,V} from the ALU this cycle
ALUResultE  in  DATA_W  ALU output
WriteDataE  in  DATA_W  store data
WA3E  in  REG_AW  destination register
stall_m  in  1  hold EX/MEM register and flags
flush_m  in  1  kill the EXE instruction; insert bubble
CondExE  out  1  combinational condition-pass for the EXE instruction
FlagsQ  out  4  architectural {N,Z,C,V}
valid_m  out  1  MEM-stage instruction valid
RegWriteM  out  1  gated register write
MemWriteM  out  1  gated memory write
MemtoRegM  out  1  passed through
PCSrcM  out  1  gated PC write
ALUResultM  out  DATA_W  registered ALU result
WriteDataM  out  DATA_W  registered store data
WA3M  out  REG_AW  registered destination

Behaviour:
- Reset (rst_n=0, async): FlagsQ=4'b0000 and valid_m=0. RegWriteM, MemWriteM, MemtoRegM and PCSrcM are 0. ALUResultM, WriteDataM and WA3M are 0. Reset mid-stall or mid-flush overrides both.
- Condition decode, combinational from CondE and FlagsQ:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: treated as AL (1)
- CondExE = condition result AND valid_e.
- Gating: RegWrite_g = RegWriteE&CondExE; MemWrite_g = MemWriteE&CondExE; PCSrc_g = PCSrcE&CondExE. Flag updates are also gated by CondExE.
- Flags update on the rising edge only when CondExE=1, stall_m=0 and flush_m=0:
  - FlagWriteE[1] loads N,Z from ALUFlagsE.
  - FlagWriteE[0] loads C,V from ALUFlagsE.
  - The two halves are independent.
- The instruction in EXE sees the flags written by the instruction now in MEM. That instruction updated FlagsQ on the previous edge, so no flag bypass is needed and latency is 0.
- EX/MEM register, one cycle latency, priority flush > stall > advance:
  - flush_m=1: valid_m, RegWriteM, MemWriteM, MemtoRegM and PCSrcM go to 0. Data fields may hold any value; the bench must not check them. FlagsQ is unchanged.
  - stall_m=1 with flush_m=0: all M outputs and FlagsQ hold.
  - Otherwise: valid_m<=valid_e and control <= gated values. MemtoRegM<=MemtoRegE&CondExE. Data fields load from E.
- A failed condition still advances as valid_m=1 with all write enables 0 (a retired no-op).
- Bubble input (valid_e=0) produces valid_m=0 and zero enables, regardless of CondE.

Decomposition:
- Shared package pipe_pkg:
  - cond_e enum (EQ..AL, 4 bits)
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - flags_t typedef
  - DATA_W/REG_AW defaults
- One sub-module, cond_check: combinational CondE × flags → pass. Reused by the branch predictor-check later.
- Flags register and EX/MEM register stay in the top.

Test Plan:
- Reset with rst_n=0 mid-cycle → all outputs 0 immediately (async), FlagsQ=0000.
- CMP-style: FlagWriteE=11, ALUFlagsE=0100, CondE=AL, valid_e=1 → next edge FlagsQ=0100. Then CondE=EQ, RegWriteE=1 → CondExE=1, next edge RegWriteM=1, valid_m=1.
- FlagsQ=0100, CondE=NE, MemWriteE=1, PCSrcE=1 → CondExE=0, MemWriteM=0, PCSrcM=0, valid_m=1. Also FlagWriteE=11, ALUFlagsE=1001 leaves FlagsQ=0100.
- Partial update: FlagsQ=0000, FlagWriteE=10, ALUFlagsE=1111 → FlagsQ=1100.
- stall_m=1 for 2 cycles with new E inputs (ALUResultE=32'hDEADBEEF, FlagWriteE=11) → M outputs and FlagsQ unchanged. After release they load on the next edge.
- flush_m=1 and stall_m=1 together with RegWriteE=1, CondE=AL → valid_m=0, RegWriteM=0, FlagsQ unchanged. GT/LE sweep over all 16 NZCV values matches the decode table.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: condition codes, NZCV flag layout and default widths.
package pipe_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int REG_AW_DEF = 4;

   // Bit positions inside the packed {N,Z,C,V} flags word.
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef logic [3:0] flags_t;

   // ARM condition field encodings; 4'hF is executed unconditionally here.
   typedef enum logic [3:0] {
      COND_EQ = 4'h0,
      COND_NE = 4'h1,
      COND_CS = 4'h2,
      COND_CC = 4'h3,
      COND_MI = 4'h4,
      COND_PL = 4'h5,
      COND_VS = 4'h6,
      COND_VC = 4'h7,
      COND_HI = 4'h8,
      COND_LS = 4'h9,
      COND_GE = 4'hA,
      COND_LT = 4'hB,
      COND_GT = 4'hC,
      COND_LE = 4'hD,
      COND_AL = 4'hE,
      COND_NV = 4'hF
   } cond_e;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: condition field x NZCV -> pass.
// Kept standalone so the branch check logic can reuse it.
module cond_check
   import pipe_pkg::*;
(
   input  logic [3:0] cond,
   input  flags_t     flags,
   output logic       pass
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   // Decode the condition field against the current flags.
   always_comb begin
      pass = 1'b1;
      case (cond_e'(cond))
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b1;
         default: pass = 1'b1;
      endcase
   end

endmodule

// File: rtl/exmem_cond.sv
// EXE->MEM boundary: owns the NZCV register, evaluates the condition of the
// instruction in EXE, squashes its side effects on failure and registers the
// surviving bundle into MEM. Flush beats stall beats advance.
module exmem_cond
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_e,
   input  logic              RegWriteE,
   input  logic              MemWriteE,
   input  logic              MemtoRegE,
   input  logic              PCSrcE,
   input  logic [3:0]        CondE,
   input  logic [1:0]        FlagWriteE,
   input  logic [3:0]        ALUFlagsE,
   input  logic [DATA_W-1:0] ALUResultE,
   input  logic [DATA_W-1:0] WriteDataE,
   input  logic [REG_AW-1:0] WA3E,
   input  logic              stall_m,
   input  logic              flush_m,
   output logic              CondExE,
   output logic [3:0]        FlagsQ,
   output logic              valid_m,
   output logic              RegWriteM,
   output logic              MemWriteM,
   output logic              MemtoRegM,
   output logic              PCSrcM,
   output logic [DATA_W-1:0] ALUResultM,
   output logic [DATA_W-1:0] WriteDataM,
   output logic [REG_AW-1:0] WA3M
);

   logic   condPass;
   logic   advance;
   logic   regWriteG, memWriteG, memtoRegG, pcSrcG;
   flags_t flagsNext;

   // Flags are read straight from the register: the producer now in MEM
   // wrote them on the previous edge, so no bypass path is required.
   cond_check uCondCheck (
      .cond  (CondE),
      .flags (FlagsQ),
      .pass  (condPass)
   );

   assign CondExE   = condPass & valid_e;
   assign advance   = ~stall_m & ~flush_m;

   assign regWriteG = RegWriteE & CondExE;
   assign memWriteG = MemWriteE & CondExE;
   assign memtoRegG = MemtoRegE & CondExE;
   assign pcSrcG    = PCSrcE & CondExE;

   // Merge the ALU flags into the architectural ones; N/Z and C/V halves
   // are written independently, and only by an executing instruction.
   always_comb begin
      flagsNext = FlagsQ;
      if (CondExE) begin
         if (FlagWriteE[1]) begin
            flagsNext[FLAG_N] = ALUFlagsE[FLAG_N];
            flagsNext[FLAG_Z] = ALUFlagsE[FLAG_Z];
         end
         if (FlagWriteE[0]) begin
            flagsNext[FLAG_C] = ALUFlagsE[FLAG_C];
            flagsNext[FLAG_V] = ALUFlagsE[FLAG_V];
         end
      end
   end

   // Architectural flags register; frozen on stall and on flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         FlagsQ <= '0;
      end else if (advance) begin
         FlagsQ <= flagsNext;
      end
   end

   // EX/MEM control fields: flush inserts a bubble, stall holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_m   <= 1'b0;
         RegWriteM <= 1'b0;
         MemWriteM <= 1'b0;
         MemtoRegM <= 1'b0;
         PCSrcM    <= 1'b0;
      end else if (flush_m) begin
         valid_m   <= 1'b0;
         RegWriteM <= 1'b0;
         MemWriteM <= 1'b0;
         MemtoRegM <= 1'b0;
         PCSrcM    <= 1'b0;
      end else if (!stall_m) begin
         valid_m   <= valid_e;
         RegWriteM <= regWriteG;
         MemWriteM <= memWriteG;
         MemtoRegM <= memtoRegG;
         PCSrcM    <= pcSrcG;
      end
   end

   // EX/MEM data fields: meaningless behind a bubble, so flush just holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ALUResultM <= '0;
         WriteDataM <= '0;
         WA3M       <= '0;
      end else if (advance) begin
         ALUResultM <= ALUResultE;
         WriteDataM <= WriteDataE;
         WA3M       <= WA3E;
      end
   end

endmodule
